// File: rtl/ccd_pkg.sv
// Shared types and default constants for the CCD pixel stream block.
//   pix_t       : 16-bit pixel sample
//   line_cnt_t  : 12-bit per-line pixel count
//   state_e     : framing FSM states
//   fifo_word_t : output FIFO entry {data, sol, eol}, 18 bits
package ccd_pkg;

    typedef logic [15:0] pix_t;
    typedef logic [11:0] line_cnt_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DARK   = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    typedef struct packed {
        pix_t data;
        logic sol;
        logic eol;
    } fifo_word_t;

    localparam int unsigned DARK_PIX_LOG2  = 4;
    localparam int unsigned GAP_CYCLES_DEF = 200;
    localparam int unsigned FIFO_DEPTH_DEF = 16;
    localparam int unsigned LINE_MAX_DEF   = 4095;

    // Black-level subtraction with floor at zero.
    function automatic pix_t sub_floor(input pix_t a, input pix_t b);
        return (a > b) ? pix_t'(a - b) : '0;
    endfunction

endpackage

// File: rtl/ccd_stream_fifo.sv
// Synchronous FIFO of fifo_word_t entries with show-ahead read.
//   clk_80M, rst_n : clock, async active-low reset
//   push_i/wdata_i : write request and data (ignored when full unless a pop
//                    happens in the same cycle)
//   pop_i          : read request (ignored when empty)
//   rdata_o        : head entry, combinational from storage; zero when empty
//   full_o/empty_o : occupancy flags
module ccd_stream_fifo
    import ccd_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk_80M,
    input  logic       rst_n,
    input  logic       push_i,
    input  fifo_word_t wdata_i,
    input  logic       pop_i,
    output fifo_word_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    fifo_word_t     mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;
    logic           do_push;
    logic           do_pop;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign do_push = push_i && (!full_o || do_pop);

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk_80M) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ccd_pixel_stream.sv
// CCD pixel stream framer.
// Synchronises the pixel strobe, frames pixels into lines using the inter-line
// gap, strips the dark reference pixels into a black level (normal mode) and
// streams the result through a small FIFO.
//   clk_80M, rst_n          : clock, async active-low reset
//   en                      : 0 abandons the current line (FIFO keeps draining)
//   cal_mode                : 1 = raw pass-through, sampled at line start
//   pix_clk, pix_data       : async pixel strobe (falling edge) and sample
//   out_data/out_valid/out_ready/out_sol/out_eol : output stream
//   line_len, line_done     : forwarded count of last line, close pulse
//   black_level             : black level of the current/last normal line
//   overflow                : sticky, a push was dropped on a full FIFO
//
// state  | meaning
// IDLE   | waiting for the first strobe of a line
// DARK   | accumulating dark reference pixels
// ACTIVE | forwarding pixels through the one-entry staging register
module ccd_pixel_stream
    import ccd_pkg::*;
#(
    parameter int unsigned DARK_PIX   = (1 << DARK_PIX_LOG2),
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned LINE_MAX   = LINE_MAX_DEF
) (
    input  logic      clk_80M,
    input  logic      rst_n,
    input  logic      en,
    input  logic      cal_mode,
    input  logic      pix_clk,
    input  pix_t      pix_data,
    output pix_t      out_data,
    output logic      out_valid,
    input  logic      out_ready,
    output logic      out_sol,
    output logic      out_eol,
    output line_cnt_t line_len,
    output logic      line_done,
    output pix_t      black_level,
    output logic      overflow
);

    localparam int unsigned DP_LOG2 = $clog2(DARK_PIX);
    localparam int unsigned ACC_W   = 16 + DP_LOG2;
    localparam int unsigned IDX_W   = (DP_LOG2 < 1) ? 1 : DP_LOG2;
    localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

    // Strobe synchroniser: two metastability stages plus an edge register.
    logic pix_s1_q;
    logic pix_s2_q;
    logic pix_s3_q;
    logic strobe;

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            pix_s1_q <= 1'b0;
            pix_s2_q <= 1'b0;
            pix_s3_q <= 1'b0;
        end else begin
            pix_s1_q <= pix_clk;
            pix_s2_q <= pix_s1_q;
            pix_s3_q <= pix_s2_q;
        end
    end

    assign strobe = pix_s3_q & ~pix_s2_q;

    // Gap counter: cleared by every strobe, saturates at GAP_CYCLES.
    logic [GAP_W-1:0] gap_q;
    logic             gap_close;

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else if (strobe) begin
            gap_q <= '0;
        end else if (gap_q != GAP_W'(GAP_CYCLES)) begin
            gap_q <= gap_q + GAP_W'(1);
        end
    end

    // Fires in the cycle where the counter is about to reach GAP_CYCLES;
    // a strobe in the same cycle always wins.
    assign gap_close = !strobe && (gap_q == GAP_W'(GAP_CYCLES - 1));

    // Framing FSM and datapath registers.
    state_e           state_q;
    logic             cal_line_q;
    logic             first_q;
    logic             stage_vld_q;
    pix_t             stage_q;
    pix_t             black_q;
    logic [ACC_W-1:0] acc_q;
    logic [IDX_W-1:0] dark_idx_q;
    line_cnt_t        fwd_cnt_q;
    line_cnt_t        line_len_q;
    logic             line_done_q;
    logic             push_q;
    fifo_word_t       push_word_q;

    logic [ACC_W-1:0] acc_sum;
    pix_t             active_val;

    assign acc_sum    = acc_q + ACC_W'(pix_data);
    assign active_val = cal_line_q ? pix_data : sub_floor(pix_data, black_q);

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cal_line_q  <= 1'b0;
            first_q     <= 1'b0;
            stage_vld_q <= 1'b0;
            stage_q     <= '0;
            black_q     <= '0;
            acc_q       <= '0;
            dark_idx_q  <= '0;
            fwd_cnt_q   <= '0;
            line_len_q  <= '0;
            line_done_q <= 1'b0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            push_q      <= 1'b0;
            line_done_q <= 1'b0;
            if (!en) begin
                // Abandon the line; the staged pixel is dropped without an eol.
                state_q     <= IDLE;
                stage_vld_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (strobe) begin
                            // The line-opening strobe is also the first pixel.
                            cal_line_q <= cal_mode;
                            first_q    <= 1'b1;
                            if (cal_mode) begin
                                stage_q     <= pix_data;
                                stage_vld_q <= 1'b1;
                                fwd_cnt_q   <= line_cnt_t'(1);
                                state_q     <= ACTIVE;
                            end else begin
                                acc_q       <= ACC_W'(pix_data);
                                dark_idx_q  <= IDX_W'(1);
                                stage_vld_q <= 1'b0;
                                fwd_cnt_q   <= '0;
                                state_q     <= DARK;
                            end
                        end
                    end
                    DARK: begin
                        if (strobe) begin
                            acc_q      <= acc_sum;
                            dark_idx_q <= dark_idx_q + IDX_W'(1);
                            if (dark_idx_q == IDX_W'(DARK_PIX - 1)) begin
                                black_q <= acc_sum[DP_LOG2 +: 16];
                                state_q <= ACTIVE;
                            end
                        end else if (gap_close) begin
                            line_done_q <= 1'b1;
                            line_len_q  <= '0;
                            state_q     <= IDLE;
                        end
                    end
                    ACTIVE: begin
                        if (strobe) begin
                            if (stage_vld_q) begin
                                push_q      <= 1'b1;
                                push_word_q <= '{data: stage_q, sol: first_q, eol: 1'b0};
                                first_q     <= 1'b0;
                            end
                            stage_q     <= active_val;
                            stage_vld_q <= 1'b1;
                            if (fwd_cnt_q != line_cnt_t'(LINE_MAX)) begin
                                fwd_cnt_q <= fwd_cnt_q + line_cnt_t'(1);
                            end
                        end else if (gap_close) begin
                            if (stage_vld_q) begin
                                push_q      <= 1'b1;
                                push_word_q <= '{data: stage_q, sol: first_q, eol: 1'b1};
                            end
                            first_q     <= 1'b0;
                            stage_vld_q <= 1'b0;
                            line_done_q <= 1'b1;
                            line_len_q  <= fwd_cnt_q;
                            state_q     <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Output FIFO and sticky overflow.
    fifo_word_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       overflow_q;

    assign fifo_pop = !fifo_empty && out_ready;

    ccd_stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_80M (clk_80M),
        .rst_n   (rst_n),
        .push_i  (push_q),
        .wdata_i (push_word_q),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (push_q && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign out_data    = head.data;
    assign out_sol     = head.sol;
    assign out_eol     = head.eol;
    assign out_valid   = !fifo_empty;
    assign line_len    = line_len_q;
    assign line_done   = line_done_q;
    assign black_level = black_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ccd_pixel_stream.sv
module tb_ccd_pixel_stream;
    import ccd_pkg::*;

    localparam int DP   = 16;
    localparam int GAP  = 200;
    localparam int LMAX = 150;

    logic        clk_80M = 1'b0;
    logic        rst_n;
    logic        en;
    logic        cal_mode;
    logic        pix_clk;
    logic [15:0] pix_data;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_sol;
    logic        out_eol;
    logic [11:0] line_len;
    logic        line_done;
    logic [15:0] black_level;
    logic        overflow;

    ccd_pixel_stream #(
        .DARK_PIX   (DP),
        .GAP_CYCLES (GAP),
        .FIFO_DEPTH (16),
        .LINE_MAX   (LMAX)
    ) dut (
        .clk_80M     (clk_80M),
        .rst_n       (rst_n),
        .en          (en),
        .cal_mode    (cal_mode),
        .pix_clk     (pix_clk),
        .pix_data    (pix_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sol     (out_sol),
        .out_eol     (out_eol),
        .line_len    (line_len),
        .line_done   (line_done),
        .black_level (black_level),
        .overflow    (overflow)
    );

    always #5 clk_80M = ~clk_80M;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int last_fall  = 0;

    logic [15:0] samp_q[$];
    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    int          done_len_q[$];
    int          done_cyc_q[$];
    logic [15:0] exp_black;
    logic [15:0] prev_black;
    int          exp_len;

    always @(posedge clk_80M) cyc <= cyc + 1;

    // Capture accepted words and line-close pulses between clock edges.
    always @(negedge clk_80M) begin
        #1;
        if (rst_n && out_valid && out_ready) got_q.push_back({out_data, out_sol, out_eol});
        if (rst_n && line_done) begin
            done_len_q.push_back(int'(line_len));
            done_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_80M);
    endtask

    // One pixel period of 40 cycles; data changes with the falling edge.
    task automatic send_pix(input logic [15:0] v);
        pix_clk = 1'b1;
        tick(20);
        pix_clk   = 1'b0;
        pix_data  = v;
        last_fall = cyc;
        tick(20);
    endtask

    // Reference model: a line is a list of samples; the first DP are dark in
    // normal mode and their mean is subtracted (floored) from the rest.
    task automatic build_expected(input bit cal);
        int sum;
        int n_out;
        int x;
        exp_q.delete();
        exp_black = prev_black;
        sum = 0;
        if (!cal) begin
            for (int i = 0; i < DP; i++) sum += int'(samp_q[i]);
            exp_black = 16'(sum / DP);
        end
        n_out = cal ? samp_q.size() : samp_q.size() - DP;
        for (int i = 0; i < n_out; i++) begin
            x = cal ? int'(samp_q[i]) : int'(samp_q[i + DP]);
            if (!cal) x = (x > int'(exp_black)) ? x - int'(exp_black) : 0;
            exp_q.push_back({16'(x), i == 0, i == n_out - 1});
        end
        exp_len = (n_out > LMAX) ? LMAX : n_out;
    endtask

    task automatic clear_mon();
        got_q.delete();
        done_len_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic wait_done();
        for (int i = 0; i < GAP + 80; i++) begin
            if (done_len_q.size() != 0) break;
            tick(1);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (!out_valid) break;
            tick(1);
        end
        check({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    task automatic check_words(input string tag, input int n);
        int m;
        check({tag, "_nwords"}, 32'(got_q.size()), 32'(n));
        m = (got_q.size() < n) ? got_q.size() : n;
        for (int i = 0; i < m; i++)
            check($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic full_line(input bit cal, input int toggle_at, input string tag);
        build_expected(cal);
        cal_mode = cal;
        clear_mon();
        foreach (samp_q[i]) begin
            if (i == toggle_at) cal_mode = ~cal_mode;
            send_pix(samp_q[i]);
        end
        wait_done();
        check({tag, "_ndone"}, 32'(done_len_q.size()), 32'd1);
        if (done_len_q.size() == 1) begin
            check({tag, "_len"}, 32'(done_len_q[0]), 32'(exp_len));
            check({tag, "_done_lat"}, 32'(done_cyc_q[0] - last_fall), 32'(GAP + 3));
        end
        tick(3);
        drain(tag);
        check({tag, "_black"}, 32'(black_level), 32'(exp_black));
        check_words(tag, exp_q.size());
        prev_black = exp_black;
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        cal_mode   = 1'b0;
        pix_clk    = 1'b0;
        pix_data   = '0;
        out_ready  = 1'b1;
        prev_black = '0;
        tick(3);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_sol", 32'(out_sol), 32'd0);
        check("rst_eol", 32'(out_eol), 32'd0);
        check("rst_len", 32'(line_len), 32'd0);
        check("rst_done", 32'(line_done), 32'd0);
        check("rst_black", 32'(black_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        tick(5);

        // Flat line: black 1000, every output 500, count saturates at LMAX.
        samp_q.delete();
        repeat (DP) samp_q.push_back(16'd1000);
        repeat (200) samp_q.push_back(16'd1500);
        full_line(1'b0, -1, "flat");

        // Dark level above signal: floor at zero.
        samp_q.delete();
        repeat (DP) samp_q.push_back(16'd3000);
        samp_q.push_back(16'd2000);
        samp_q.push_back(16'd3500);
        full_line(1'b0, -1, "floor");

        // Calibration ramp; cal_mode flipped mid-line must not matter.
        samp_q.delete();
        for (int i = 0; i < 60; i++) samp_q.push_back(16'(i));
        full_line(1'b1, 5, "cal");

        // Random normal line.
        samp_q.delete();
        repeat (DP) samp_q.push_back(16'($urandom_range(1000, 5000)));
        repeat (60) samp_q.push_back(16'($urandom_range(0, 8000)));
        full_line(1'b0, -1, "rand");

        // Stalled output: 16 words kept, overflow from the 17th push.
        out_ready = 1'b0;
        samp_q.delete();
        repeat (DP) samp_q.push_back(16'($urandom_range(0, 4000)));
        repeat (40) samp_q.push_back(16'($urandom_range(0, 20000)));
        build_expected(1'b0);
        cal_mode = 1'b0;
        clear_mon();
        for (int i = 0; i < samp_q.size(); i++) begin
            send_pix(samp_q[i]);
            if (i == DP + 16) check("ovf_at16", 32'(overflow), 32'd0);
            if (i == DP + 17) check("ovf_at17", 32'(overflow), 32'd1);
        end
        wait_done();
        check("ovf_ndone", 32'(done_len_q.size()), 32'd1);
        check("ovf_len", 32'(line_len), 32'd40);
        check("ovf_valid", 32'(out_valid), 32'd1);
        check("ovf_nopop", 32'(got_q.size()), 32'd0);
        out_ready = 1'b1;
        tick(2);
        drain("ovf");
        check_words("ovf", 16);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_black", 32'(black_level), 32'(exp_black));
        prev_black = exp_black;

        // en dropped after 100 active strobes: 99 words, no eol, no close.
        samp_q.delete();
        repeat (DP) samp_q.push_back(16'($urandom_range(0, 4000)));
        repeat (100) samp_q.push_back(16'($urandom_range(0, 20000)));
        build_expected(1'b0);
        cal_mode = 1'b0;
        clear_mon();
        foreach (samp_q[i]) send_pix(samp_q[i]);
        en = 1'b0;
        tick(5);
        en = 1'b1;
        tick(GAP + 20);
        drain("endrop");
        check("endrop_ndone", 32'(done_len_q.size()), 32'd0);
        check_words("endrop", 99);
        check("endrop_black", 32'(black_level), 32'(exp_black));
        check("endrop_len_held", 32'(line_len), 32'd40);
        prev_black = exp_black;

        samp_q.delete();
        repeat (3) samp_q.push_back(16'($urandom_range(0, 65535)));
        full_line(1'b1, -1, "after_en");

        // Asynchronous reset in the middle of a line.
        out_ready = 1'b0;
        cal_mode  = 1'b1;
        for (int i = 0; i < 5; i++) send_pix(16'($urandom_range(1, 65535)));
        check("prerst_valid", 32'(out_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        check("arst_sol", 32'(out_sol), 32'd0);
        check("arst_len", 32'(line_len), 32'd0);
        check("arst_black", 32'(black_level), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        @(negedge clk_80M);
        rst_n      = 1'b1;
        out_ready  = 1'b1;
        prev_black = '0;
        tick(5);

        samp_q.delete();
        samp_q.push_back(16'd777);
        full_line(1'b1, -1, "single");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ccd_pixel_stream.md
Name: ccd_pixel_stream

Overview:
- Downstream consumer of the CCD timing/ADC readout stage, all in the clk_80M domain.
- Synchronises pix_clk, captures pix_data on each pixel strobe and frames pixels into lines using the inter-line gap.
- Normal mode: the first DARK_PIX pixels of each line are averaged into a black level, which is subtracted with floor at 0 from the remaining pixels. Calibration mode: all pixels are forwarded raw.
- Output is a valid/ready stream with start/end-of-line flags, buffered by a small FIFO toward the host/USB packer.

Parameters:
DARK_PIX, 16, dark reference pixels per line in normal mode; power of 2, 2..64
GAP_CYCLES, 200, clk_80M cycles without a pixel strobe that close a line
FIFO_DEPTH, 16, output FIFO entries; power of 2
LINE_MAX, 4095, saturation value of the per-line pixel counter

Ports:
clk_80M  in  1  system clock, 80 MHz
rst_n  in  1  asynchronous active-low reset
en  in  1  enable; 0 flushes framing state (the FIFO keeps draining)
cal_mode  in  1  1 = raw pass-through of all pixels, no dark stripping
pix_clk  in  1  pixel strobe from readout stage; treat as asynchronous
pix_data  in  16  pixel value, updated on pix_clk falling edge
out_data  out  16  pixel value
out_valid  out  1  out_data/out_sol/out_eol valid
out_ready  in  1  downstream accept
out_sol  out  1  first forwarded pixel of a line
out_eol  out  1  last forwarded pixel of a line
line_len  out  12  forwarded pixel count of last completed line
line_done  out  1  one-cycle pulse when a line closes
black_level  out  16  black level of the current/last line
overflow  out  1  sticky; FIFO full on a push; cleared only by reset

Behaviour:
- Reset values: all outputs 0; FIFO empty; state IDLE; counters 0.
- pix_clk passes a 2-FF synchroniser plus an edge register.
- A synchronised falling edge is a strobe. pix_data is sampled on the strobe cycle, 3 cycles after the async edge, and is stable for at least 36 cycles.
- State IDLE: the first strobe while en=1 moves to the next state and clears acc, pixel index and gap counter.
  - cal_mode=0: next state is DARK.
  - cal_mode=1: next state is ACTIVE.
  - cal_mode is latched at line start and is ignored mid-line.
- State DARK: each strobe adds the sample to acc (width 16+log2(DARK_PIX), no overflow possible).
  - On the DARK_PIX-th strobe: black_level = acc >> log2(DARK_PIX); go to ACTIVE.
  - Dark pixels are never forwarded.
- State ACTIVE: each strobe produces a value.
  - cal_mode line: value = raw sample.
  - Normal line: value = sample - black_level, 0 if negative.
  - The value goes into a one-entry staging register. The previous staged value, if any, is pushed to the FIFO first, with sol=1 if it is the line's first forwarded pixel.
- Gap counter: reset on every strobe, increments otherwise, saturates at GAP_CYCLES.
  - Reaching GAP_CYCLES in ACTIVE: push the staged pixel with eol=1 (sol=1 too if it is the only pixel).
  - Same event: line_len = forwarded count, line_done pulse, return to IDLE.
  - Reaching GAP_CYCLES in DARK: line_done pulse, line_len=0, nothing pushed, return to IDLE.
- Forwarded count saturates at LINE_MAX.
- Push and gap-close are mutually exclusive: the gap counter reset wins on a strobe cycle.
- FIFO:
  - Push when full: the data is dropped and overflow is set to 1.
  - out_valid = !empty.
  - A pop occurs when out_valid && out_ready.
  - A simultaneous push and pop when full is accepted (no overflow).
  - Show-ahead: out_data reflects the head entry combinationally from registered storage.
- en=0 at any time: state goes to IDLE and the staging register is discarded (no eol is generated). The FIFO contents stay and drain; black_level and line_len are held.
- Strobe-to-FIFO latency: a pixel reaches the FIFO on the next strobe, or GAP_CYCLES+1 cycles after its own strobe if it is last.
- An empty-FIFO push appears on out_valid the cycle after the push.

Decomposition:
- Package ccd_pkg holds:
  - pix_t (logic [15:0]), line_cnt_t (logic [11:0]);
  - state enum {IDLE, DARK, ACTIVE};
  - fifo word struct {pix_t data; logic sol; logic eol} (18 bits);
  - shared constants DARK_PIX_LOG2 and GAP_CYCLES defaults.
- One sub-module, ccd_stream_fifo: synchronous FIFO of fifo words, FIFO_DEPTH entries, with full/empty outputs and show-ahead read.

Test Plan:
- Normal line, 2088 strobes at a 40-cycle period with pix_data = 1000 for the first 16 strobes and then 1500, out_ready=1 -> black_level=1000; 2072 outputs of 500; sol on the first, eol on the last; line_len=2072; one line_done pulse GAP_CYCLES cycles after the last strobe.
- Dark level above signal (16 dark strobes at 3000, then values 2000, 3500) -> outputs 0 then 500 (floor at 0 holds).
- cal_mode=1, 2049 strobes with pix_data = ramp 0..2048 -> 2049 raw outputs 0..2048; black_level unchanged; line_len=2049; cal_mode toggled mid-line has no effect until the next line.
- out_ready=0 for a whole normal line -> first 16 outputs buffered, overflow=1 from the 17th push. After out_ready=1 exactly those 16 drain, and overflow remains 1.
- en dropped after 100 active strobes -> state IDLE, no eol emitted, at most 99 entries pushed (FIFO-limited). A new line after en=1 starts with sol=1.
- rst_n pulsed low mid-line asynchronously (not aligned to clk_80M) -> all outputs 0 immediately, FIFO empty; a single-pixel ACTIVE line afterwards gives one word with sol=eol=1 and line_len=1.
